// File: rtl/tsp_pkg.sv
// Shared constants, scheduler state encoding and cost arithmetic for the 2-opt scheduler.
package tsp_pkg;

  localparam int N_CITY = 8;
  localparam int COST_W = 16;
  localparam int IDX_W  = $clog2(N_CITY);

  typedef enum logic [2:0] {IDLE, EVAL, APPLY, ADV, DONE} sched_state_t;

  // Adds a signed delta to an unsigned cost; a result below zero becomes zero.
  function automatic logic [COST_W-1:0] clamp_add(input logic [COST_W-1:0] cost,
                                                 input logic signed [COST_W:0] delta);
    logic signed [COST_W+1:0] sum;
    sum = $signed({2'b00, cost}) + $signed({delta[COST_W], delta});
    return sum[COST_W+1] ? '0 : sum[COST_W-1:0];
  endfunction

endpackage

// File: rtl/tsp_pair_iter.sv
// Enumerates 2-opt city pairs (i,j), j >= i+2, skipping (0,N-1) which is the same edge pair.
module tsp_pair_iter
  import tsp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             wrap
);

  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(N_CITY - 1);
  localparam logic [IDX_W-1:0] J_SKIP = IDX_W'(N_CITY - 2);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(N_CITY - 3);

  assign wrap = (i == I_LAST) && (j == J_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      i <= '0;
      j <= '0;
    end else if (clear || (step && wrap)) begin
      i <= '0;
      j <= IDX_W'(2);
    end else if (step) begin
      if (j == J_LAST) begin
        i <= i + IDX_W'(1);
        j <= i + IDX_W'(3);
      end else if (i == '0 && j == J_SKIP) begin
        // (0,N-1) would swap the two edges meeting at city 0: nothing to gain
        i <= IDX_W'(1);
        j <= IDX_W'(3);
      end else begin
        j <= j + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/tsp_2opt_sched.sv
// 2-opt search sequencer: issues pairs to the evaluator, applies improving swaps, counts passes.
module tsp_2opt_sched
  import tsp_pkg::*;
#(
  parameter int PASS_W   = 8,
  parameter int MAX_PASS = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [COST_W-1:0]        init_cost,
  output logic                     ev_req,
  output logic [IDX_W-1:0]         ev_i,
  output logic [IDX_W-1:0]         ev_j,
  input  logic                     ev_ack,
  input  logic signed [COST_W:0]   ev_delta,
  output logic                     ap_req,
  input  logic                     ap_ack,
  output logic                     busy,
  output logic                     done,
  output logic [COST_W-1:0]        best_cost,
  output logic [PASS_W-1:0]        pass_cnt,
  output logic [15:0]              improve_cnt,
  output logic [3:0]               state_led,
  output sched_state_t             state_dbg
);

  // Handshake: a req rises when its state is entered and holds with indices
  // stable; an ack in any cycle req is high (including the first) completes
  // the transfer and req drops on the following edge. Acks with req low are ignored.

  sched_state_t              state, state_nxt;
  logic                      start_d;
  logic                      launch;
  logic                      it_clear, it_step, it_wrap;
  logic                      pass_improved;
  logic                      max_stop;
  logic signed [COST_W:0]    delta_q;
  logic [PASS_W-1:0]         pass_next;
  logic                      max_hit;

  tsp_pair_iter u_iter (
    .clk   (clk),
    .rst   (rst),
    .clear (it_clear),
    .step  (it_step),
    .i     (ev_i),
    .j     (ev_j),
    .wrap  (it_wrap)
  );

  assign launch    = start && !start_d && (state == IDLE || state == DONE);
  assign pass_next = pass_cnt + PASS_W'(1);
  assign max_hit   = (pass_next == PASS_W'(MAX_PASS));

  assign ev_req    = (state == EVAL);
  assign ap_req    = (state == APPLY);
  assign busy      = (state == EVAL) || (state == APPLY) || (state == ADV);
  assign done      = (state == DONE);
  assign state_led = {max_stop, done, ap_req, busy};
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    it_clear  = 1'b0;
    it_step   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (launch) begin
          it_clear  = 1'b1;
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        if (ev_ack) state_nxt = ev_delta[COST_W] ? APPLY : ADV;
      end
      APPLY: begin
        if (ap_ack) state_nxt = ADV;
      end
      ADV: begin
        it_step = 1'b1;
        if (it_wrap && (!pass_improved || max_hit)) state_nxt = DONE;
        else                                        state_nxt = EVAL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      start_d       <= 1'b1;
      best_cost     <= '0;
      pass_cnt      <= '0;
      improve_cnt   <= '0;
      pass_improved <= 1'b0;
      max_stop      <= 1'b0;
      delta_q       <= '0;
    end else begin
      start_d <= start;
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            best_cost     <= init_cost;
            pass_cnt      <= '0;
            improve_cnt   <= '0;
            pass_improved <= 1'b0;
            max_stop      <= 1'b0;
          end
        end
        EVAL: begin
          if (ev_ack) delta_q <= ev_delta;
        end
        APPLY: begin
          if (ap_ack) begin
            best_cost     <= clamp_add(best_cost, delta_q);
            pass_improved <= 1'b1;
            if (improve_cnt != 16'hFFFF) improve_cnt <= improve_cnt + 16'd1;
          end
        end
        ADV: begin
          if (it_wrap) begin
            pass_cnt <= pass_next;
            // Still improving but out of passes: remember the forced stop
            if (pass_improved && max_hit) max_stop      <= 1'b1;
            else if (pass_improved)       pass_improved <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tsp_2opt_sched.sv
// Bench for tsp_2opt_sched: randomized evaluator/apply responder checked against a pass-level model.
module tb_tsp_2opt_sched;
  import tsp_pkg::*;

  localparam int MAXP  = 3;
  localparam int PW    = 2 * IDX_W;
  localparam int NPAIR = N_CITY * (N_CITY - 3) / 2;

  logic                   clk, rst, start;
  logic [COST_W-1:0]      init_cost;
  logic                   ev_req, ev_ack, ap_req, ap_ack, busy, done;
  logic [IDX_W-1:0]       ev_i, ev_j;
  logic signed [COST_W:0] ev_delta;
  logic [COST_W-1:0]      best_cost;
  logic [7:0]             pass_cnt;
  logic [15:0]            improve_cnt;
  logic [3:0]             state_led;
  sched_state_t           state_dbg;

  tsp_2opt_sched #(.PASS_W(8), .MAX_PASS(MAXP)) dut (
    .clk(clk), .rst(rst), .start(start), .init_cost(init_cost),
    .ev_req(ev_req), .ev_i(ev_i), .ev_j(ev_j), .ev_ack(ev_ack), .ev_delta(ev_delta),
    .ap_req(ap_req), .ap_ack(ap_ack), .busy(busy), .done(done),
    .best_cost(best_cost), .pass_cnt(pass_cnt), .improve_cnt(improve_cnt),
    .state_led(state_led), .state_dbg(state_dbg)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp_ap_q[$];
  logic [PW-1:0] obs_q[$];
  logic [PW-1:0] obs_ap_q[$];
  int            exp_cost, exp_pass, exp_impr;
  bit            exp_maxstop;

  int scn = 1;
  bit slow = 0, spurious = 0, ap_hold = 0;
  int eval_idx = 0;

  // Improving deltas per scenario; 0 means "pick a random non-negative delta".
  function automatic int neg_delta(input int s, input int pass, input int i, input int j);
    case (s)
      2:       return (pass == 0 && i == 1 && j == 4) ? -10 : 0;
      3:       return -1;
      5:       return (pass == 0 && i == 0 && j == 2) ? -10 : 0;
      6:       return (pass == 0 && i == 0 && j == 2) ? -8 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model(input int s, input int init);
    int  cost, pass, impr;
    bit  improved;
    cost = init; pass = 0; impr = 0;
    exp_q.delete();
    exp_ap_q.delete();
    do begin
      improved = 0;
      for (int i = 0; i <= N_CITY - 2; i++) begin
        for (int j = i + 2; j <= N_CITY - 1; j++) begin
          int d;
          logic [PW-1:0] pr;
          if (i == 0 && j == N_CITY - 1) continue;
          pr = {IDX_W'(i), IDX_W'(j)};
          exp_q.push_back(pr);
          d = neg_delta(s, pass, i, j);
          if (d < 0) begin
            exp_ap_q.push_back(pr);
            cost = (cost + d < 0) ? 0 : cost + d;
            if (impr < 65535) impr++;
            improved = 1;
          end
        end
      end
      pass++;
    end while (improved && pass < MAXP);
    exp_cost = cost; exp_pass = pass; exp_impr = impr;
    exp_maxstop = improved && (pass == MAXP);
  endtask

  // evaluator / apply-unit responder, driven on the falling edge
  initial begin
    int ev_cnt, ap_cnt, cur_d;
    bit ev_pend, ap_pend;
    logic [PW-1:0] cur_pair, cur_ap;
    ev_ack = 0; ap_ack = 0; ev_delta = '0;
    ev_pend = 0; ap_pend = 0; ev_cnt = 0; ap_cnt = 0; cur_d = 0;
    cur_pair = '0; cur_ap = '0;
    forever begin
      @(negedge clk);
      ev_ack = 0;
      ap_ack = 0;
      if (ev_req) begin
        if (!ev_pend) begin
          ev_pend  = 1;
          ev_cnt   = slow ? int'($urandom_range(1, 5)) : 0;
          cur_pair = {ev_i, ev_j};
          obs_q.push_back(cur_pair);
          cur_d = neg_delta(scn, eval_idx / NPAIR, int'(ev_i), int'(ev_j));
          if (cur_d == 0) cur_d = int'($urandom_range(0, 50));
          eval_idx++;
        end else begin
          chk("ev_idx_stable", 32'({ev_i, ev_j}), 32'(cur_pair));
        end
        if (ev_cnt == 0) begin
          ev_ack   = 1;
          ev_delta = (COST_W+1)'(cur_d);
          ev_pend  = 0;
        end else ev_cnt--;
      end else begin
        ev_pend = 0;
        if (spurious && $urandom_range(0, 2) == 0) begin
          ev_ack   = 1;
          ev_delta = -(COST_W+1)'(100);
        end
      end
      if (ap_req) begin
        if (!ap_pend) begin
          ap_pend = 1;
          ap_cnt  = slow ? int'($urandom_range(1, 5)) : 0;
          cur_ap  = {ev_i, ev_j};
          obs_ap_q.push_back(cur_ap);
        end else begin
          chk("ap_idx_stable", 32'({ev_i, ev_j}), 32'(cur_ap));
        end
        if (!ap_hold && ap_cnt == 0) begin
          ap_ack  = 1;
          ap_pend = 0;
        end else if (ap_cnt > 0) ap_cnt--;
      end else begin
        ap_pend = 0;
        if (spurious && $urandom_range(0, 2) == 0) ap_ack = 1;
      end
    end
  end

  task automatic do_launch(input int init);
    @(negedge clk);
    start = 0;
    @(negedge clk);
    init_cost = COST_W'(init);
    start = 1;
    eval_idx = 0;
    obs_q.delete();
    obs_ap_q.delete();
    @(negedge clk);
    chk("launch_ev_req", 32'(ev_req), 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic check_run();
    int n;
    chk("n_evals", 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) chk("eval_pair", 32'(obs_q[k]), 32'(exp_q[k]));
    chk("n_applies", 32'(obs_ap_q.size()), 32'(exp_ap_q.size()));
    n = (obs_ap_q.size() < exp_ap_q.size()) ? obs_ap_q.size() : exp_ap_q.size();
    for (int k = 0; k < n; k++) chk("apply_pair", 32'(obs_ap_q[k]), 32'(exp_ap_q[k]));
    chk("best_cost", 32'(best_cost), 32'(exp_cost));
    chk("pass_cnt", 32'(pass_cnt), 32'(exp_pass));
    chk("improve_cnt", 32'(improve_cnt), 32'(exp_impr));
    chk("state_led", 32'(state_led), 32'({exp_maxstop, 3'b100}));
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  // directed sequence
  initial begin
    int n;
    rst = 0; start = 1; init_cost = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({ev_req, ap_req, busy, done, state_led, ev_i, ev_j}), 32'd0);
    chk("reset_counts", 32'({best_cost, pass_cnt}), 32'd0);
    chk("reset_improve", 32'(improve_cnt), 32'd0);
    rst = 1;
    repeat (5) @(negedge clk);
    chk("no_launch_held_start", 32'({busy, ev_req}), 32'd0);

    // 1: no improvements, zero-wait; exact cycle count
    scn = 1; slow = 0; spurious = 0;
    do_launch(1000);
    wait_done(n);
    chk("pass_cycles", 32'(n), 32'(2 * NPAIR));
    model(1, 1000);
    check_run();

    // 2: single improvement at (1,4)
    scn = 2;
    do_launch(2000 - 1000);
    wait_done(n);
    model(2, 1000);
    check_run();

    // 3: every pair improves until the pass limit, random waits and spurious acks
    scn = 3; slow = 1; spurious = 1;
    do_launch(1000);
    wait_done(n);
    model(3, 1000);
    check_run();

    // 4: scenario 1 totals under random waits and spurious acks
    scn = 1;
    do_launch(1000);
    wait_done(n);
    model(1, 1000);
    check_run();

    // 5: reset while APPLY is pending, start held high
    scn = 5; slow = 0; spurious = 0; ap_hold = 1;
    do_launch(1000);
    n = 0;
    while (!ap_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached_apply", 32'(ap_req), 32'd1);
    rst = 0;
    @(negedge clk);
    chk("midrst_outputs", 32'({ev_req, ap_req, busy, done, state_led, ev_i, ev_j}), 32'd0);
    chk("midrst_counts", 32'({best_cost, pass_cnt}), 32'd0);
    chk("midrst_improve", 32'(improve_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1; ap_hold = 0;
    repeat (5) @(negedge clk);
    chk("no_relaunch", 32'({busy, ev_req}), 32'd0);
    scn = 1;
    do_launch(777);
    wait_done(n);
    model(1, 777);
    check_run();

    // 6: clamp to zero; a start edge during the run is ignored
    scn = 6;
    do_launch(5);
    repeat (6) @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1;
    wait_done(n);
    model(6, 5);
    check_run();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tsp_2opt_sched.md
Name: tsp_2opt_sched

Overview:
Scheduler that sequences 2-opt local search for the TSP solver. It enumerates city-index pairs (i,j) and issues each pair to a shared tour-evaluator core over a req/ack handshake. When the evaluator reports an improving delta, it commands the tour-apply unit to perform the swap. It tracks best cost, pass count and improvement count, and sits between the board-level wrapper (SW/LEDR/HEX) and the evaluator/apply datapath.

Parameters:
N_CITY, 8, number of cities; must be >= 4
COST_W, 16, unsigned tour-cost width
PASS_W, 8, pass counter width
MAX_PASS, 100, pass limit before forced stop; must be >= 1 and < 2**PASS_W

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
start  in  1  level input from SW[0]; launch is on its rising edge
init_cost  in  COST_W  cost of the initial tour, sampled at launch
ev_req  out  1  evaluate request
ev_i  out  IDX_W  pair first index; also the apply index
ev_j  out  IDX_W  pair second index; also the apply index
ev_ack  in  1  evaluator acknowledge; ev_delta is valid in this cycle
ev_delta  in  COST_W+1  signed cost change for swapping (i,j)
ap_req  out  1  apply-swap request
ap_ack  in  1  apply acknowledge
busy  out  1  search running
done  out  1  search finished; held until next launch or reset
best_cost  out  COST_W  current tour cost
pass_cnt  out  PASS_W  completed passes
improve_cnt  out  16  applied swaps; saturates at 16'hFFFF
state_led  out  4  [0]=busy, [1]=ap_req, [2]=done, [3]=MAX_PASS stop

Behaviour:
- Reset (rst=0 at a posedge):
  - State goes to IDLE. All outputs are 0 except start_d, which resets to 1.
  - Because start_d resets to 1, a start held high through reset does not launch; it must fall and rise again.
- Launch:
  - Condition: start=1 and start_d=0 at a posedge while in IDLE or DONE.
  - Effect: best_cost<=init_cost; pass_cnt, improve_cnt, pass_improved and done cleared; (i,j)<=(0,2); go to EVAL.
  - ev_req is high in the next cycle.
  - A start edge seen while busy is ignored.
- States:
  - IDLE: waits for launch.
  - EVAL: ev_req=1 with ev_i/ev_j stable.
    - On ev_ack=1 and ev_delta<0: go to APPLY.
    - On ev_ack=1 and ev_delta>=0: go to ADV.
    - An ack in the same cycle req first rises is valid (zero-wait).
  - APPLY: ap_req=1, indices held. On ap_ack=1: best_cost<=best_cost+delta_latched, improve_cnt++, pass_improved<=1, go to ADV.
  - ADV: both reqs are 0 in this cycle. Advance the pair, then go to EVAL.
    - On pair wrap, pass_cnt++ instead.
    - If pass_improved=0 or the new pass_cnt=MAX_PASS, go to DONE.
    - Otherwise clear pass_improved and go to EVAL with (0,2).
  - DONE: done=1, busy=0. state_led[3]=1 if the stop was caused by MAX_PASS while pass_improved=1.
- Pair order:
  - i ascends from 0 to N-2; for each i, j ascends from i+2 to N-1.
  - Pair (0,N-1) is skipped.
  - Total per pass is N*(N-3)/2 pairs (20 for N=8).
- Timing:
  - ev_delta is latched on the ack cycle.
  - A pass with zero-wait acks and no improvements takes exactly 2 cycles per pair.
- Clamping and saturation: best_cost+delta<0 clamps to 0; improve_cnt saturates.
- Handshake rules:
  - ev_ack while ev_req=0, and ap_ack while ap_req=0, are ignored.
  - After an ack, req falls on the next edge.
- Reset mid-transaction drops ev_req/ap_req on the next edge. The pending swap is not counted.

Decomposition:
- Package tsp_pkg holds:
  - N_CITY, COST_W, IDX_W=$clog2(N_CITY)
  - typedef enum logic [2:0] {IDLE, EVAL, APPLY, ADV, DONE} sched_state_t
- Sub-module tsp_pair_iter:
  - Inputs: clear, step.
  - Outputs: i, j, wrap.
  - Implements the pair enumeration, including the (0,N-1) skip.

Test Plan:
1. init_cost=1000, delta=+5 always, zero-wait ack -> 20 evals in order (0,2),(0,3)..(0,6),(1,3)..(5,7); done after 40 cycles from first ev_req; pass_cnt=1; best_cost=1000; improve_cnt=0.
2. delta=-10 only on (1,4) in pass 1, +1 otherwise -> exactly one ap_req with ev_i=1, ev_j=4; best_cost=990; pass_cnt=2; improve_cnt=1; state_led=4'b0100.
3. MAX_PASS=3, delta=-1 always, init_cost=1000 -> done at pass_cnt=3; improve_cnt=60; best_cost=940; state_led[3]=1.
4. ev_ack/ap_ack delayed 1-5 random cycles plus spurious acks while req=0 -> indices stable during req; spurious acks change nothing; totals match scenario 1.
5. rst=0 during APPLY with start held high -> next edge all outputs are 0; no relaunch until start goes 0 then 1.
6. init_cost=5, delta=-8 on the first pair -> best_cost=0 (clamped); start edge during busy is ignored.
